// File: rtl/tensor_tile_sequencer.sv
// tensor_tile_sequencer
// Control FSM that steps a GRID_ROWS x GRID_COLS grid of 8x8 int8 slices
// through one tiled matmul of STEPS x STEPS operations. It drives start and
// pe_reset to every slice in lockstep, gathers the per-slice done flags,
// strobes the C buffer capture and reports the ap_* handshake.
// Optional feature: define SEQ_PERF_CNT_EN to build the busy_cycles counter;
// without it busy_cycles is tied to zero.
module tensor_tile_sequencer #(
  parameter int GRID_ROWS    = 2,
  parameter int GRID_COLS    = 2,
  parameter int IDX_W        = 4,
  parameter int STEPS        = 8,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic                          ap_ce,
  input  logic                          ap_start,
  input  logic                          ap_continue,
  output logic                          ap_idle,
  output logic                          ap_ready,
  output logic                          ap_done,
  input  logic                          load_done,
  output logic [GRID_ROWS*GRID_COLS-1:0] slice_start,
  output logic                          slice_pe_reset,
  input  logic [GRID_ROWS*GRID_COLS-1:0] slice_done,
  output logic [IDX_W-1:0]              row_idx,
  output logic [IDX_W-1:0]              col_idx,
  output logic                          c_wr_en,
  output logic [IDX_W*2:0]              op_count,
  output logic                          err_timeout,
  output logic [31:0]                   busy_cycles
);

  localparam int NS    = GRID_ROWS * GRID_COLS;
  localparam int OPC_W = IDX_W * 2 + 1;
  localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(STEPS - 1);
  localparam logic [OPC_W-1:0] OPS_LAST = OPC_W'(STEPS * STEPS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOAD,
    S_ISSUE,
    S_WAIT_DONE,
    S_CAPTURE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [NS-1:0]    done_seen;
  logic [TMR_W-1:0] timer;
  logic [NS-1:0]    done_next;

  // Sticky done view including this cycle's flags, so a done arriving in the
  // first WAIT_DONE cycle moves straight on to CAPTURE.
  assign done_next = done_seen | slice_done;

  assign ap_idle  = (state == S_IDLE);
  assign ap_ready = (state == S_IDLE);
  assign ap_done  = (state == S_DONE);

  // Sequencer FSM with registered slice controls, indices and status.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state          <= S_IDLE;
      row_idx        <= '0;
      col_idx        <= '0;
      op_count       <= '0;
      done_seen      <= '0;
      timer          <= '0;
      slice_start    <= '0;
      slice_pe_reset <= 1'b0;
      c_wr_en        <= 1'b0;
      err_timeout    <= 1'b0;
    end else if (ap_ce) begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            state    <= S_WAIT_LOAD;
            row_idx  <= '0;
            col_idx  <= '0;
            op_count <= '0;
          end
        end
        S_WAIT_LOAD: begin
          if (load_done) begin
            state       <= S_ISSUE;
            slice_start <= '1;
          end
        end
        S_ISSUE: begin
          done_seen <= '0;
          timer     <= '0;
          state     <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          done_seen <= done_next;
          timer     <= timer + 1'b1;
          if (&done_next) begin
            state          <= S_CAPTURE;
            slice_start    <= '0;
            slice_pe_reset <= 1'b1;
            c_wr_en        <= 1'b1;
          end else if (timer == TMR_LAST) begin
            state       <= S_ERROR;
            slice_start <= '0;
            err_timeout <= 1'b1;
          end
        end
        S_CAPTURE: begin
          // Indices advance only after the capture cycle, and stay on the
          // final tile once the job completes.
          c_wr_en        <= 1'b0;
          slice_pe_reset <= 1'b0;
          op_count       <= op_count + 1'b1;
          if (op_count == OPS_LAST) begin
            state <= S_DONE;
          end else begin
            state       <= S_ISSUE;
            slice_start <= '1;
            if (col_idx == COL_LAST) begin
              col_idx <= '0;
              row_idx <= row_idx + 1'b1;
            end else begin
              col_idx <= col_idx + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (ap_continue) state <= S_IDLE;
        end
        S_ERROR: begin
          if (ap_continue) begin
            state       <= S_IDLE;
            err_timeout <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] busy_q;

  // Saturating count of enabled cycles spent working on a job.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      busy_q <= '0;
    end else if (ap_ce) begin
      if (state == S_IDLE) begin
        if (ap_start) busy_q <= '0;
      end else if (state != S_DONE && state != S_ERROR && busy_q != 32'hFFFF_FFFF) begin
        busy_q <= busy_q + 1'b1;
      end
    end
  end

  assign busy_cycles = busy_q;
`else
  assign busy_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_tensor_tile_sequencer.sv
// Bench for tensor_tile_sequencer: directed jobs driven against a slice
// responder, with a row-major capture model checked every cycle.
`define CHK(nm, a, e) check(nm, 64'(a), 64'(e))

module tb_tensor_tile_sequencer;
  localparam int GRID_ROWS    = 2;
  localparam int GRID_COLS    = 2;
  localparam int IDX_W        = 4;
  localparam int STEPS        = 8;
  localparam int DONE_TIMEOUT = 1024;
  localparam int NS           = GRID_ROWS * GRID_COLS;
  localparam int OPS          = STEPS * STEPS;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic ap_ce = 1'b1;
  logic ap_start = 1'b0;
  logic ap_continue = 1'b0;
  logic load_done = 1'b1;
  logic ap_idle, ap_ready, ap_done;
  logic [NS-1:0] slice_start;
  logic [NS-1:0] slice_done;
  logic slice_pe_reset;
  logic [IDX_W-1:0] row_idx, col_idx;
  logic c_wr_en;
  logic [IDX_W*2:0] op_count;
  logic err_timeout;
  logic [31:0] busy_cycles;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // slice responder configuration (negative delay = never done)
  int dly [NS];
  bit pulse_mode = 1'b1;

  // capture model state
  int cap_n = 0;
  int issue_cyc = 0;
  int exp_lat = 2;
  bit chk_lat = 1'b1;

  tensor_tile_sequencer #(
    .GRID_ROWS(GRID_ROWS), .GRID_COLS(GRID_COLS), .IDX_W(IDX_W),
    .STEPS(STEPS), .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce), .ap_start(ap_start),
    .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .ap_done(ap_done), .load_done(load_done), .slice_start(slice_start),
    .slice_pe_reset(slice_pe_reset), .slice_done(slice_done),
    .row_idx(row_idx), .col_idx(col_idx), .c_wr_en(c_wr_en),
    .op_count(op_count), .err_timeout(err_timeout), .busy_cycles(busy_cycles)
  );

  initial forever #5 ap_clk = ~ap_clk;

  initial forever begin
    @(posedge ap_clk);
    cyc++;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge ap_clk);
  endtask

  task automatic set_slices(input int d0, input int d1, input int d2, input int d3, input bit pm);
    int mx;
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    pulse_mode = pm;
    mx = 0;
    for (int i = 0; i < NS; i++) if (dly[i] > mx) mx = dly[i];
    exp_lat = mx + 1;
  endtask

  task automatic start_job(input bit hold, output int t0);
    ap_start = 1'b1;
    t0 = cyc;
    tick(1);
    if (!hold) ap_start = 1'b0;
  endtask

  task automatic wait_for_end(input int limit, output int t_end);
    int k;
    k = 0;
    while (!ap_done && !err_timeout && k < limit) begin
      tick(1);
      k++;
    end
    t_end = cyc;
    if (!ap_done && !err_timeout) begin
      n_checks++;
      n_fail++;
      $display("FAIL job_end_bound: no done or error within %0d cycles", limit);
    end
  endtask

  task automatic continue_job();
    ap_continue = 1'b1;
    tick(1);
    ap_continue = 1'b0;
  endtask

  // Slice responder: done relative to the cycle slice_start rises.
  initial begin
    int since;
    bit prev;
    since = 0;
    prev = 1'b0;
    slice_done = '0;
    forever begin
      @(negedge ap_clk);
      if (&slice_start && !prev) since = 0;
      else if (&slice_start) since++;
      prev = &slice_start;
      for (int i = 0; i < NS; i++) begin
        if (!(&slice_start) || dly[i] < 0) slice_done[i] = 1'b0;
        else if (pulse_mode) slice_done[i] = (since == dly[i]);
        else slice_done[i] = (since >= dly[i]);
      end
    end
  end

  // Compare process: captures must walk the tiles in row-major order.
  initial begin
    bit prev_start;
    bit prev_idle;
    prev_start = 1'b0;
    prev_idle = 1'b1;
    forever begin
      @(negedge ap_clk);
      #1;
      if (ap_rst) begin
        cap_n = 0;
        prev_start = 1'b0;
        prev_idle = 1'b1;
      end else begin
        if (prev_idle && !ap_idle) cap_n = 0;
        if (&slice_start && !prev_start) issue_cyc = cyc;
        `CHK("idle_vs_ready", ap_idle, ap_ready);
        `CHK("pe_reset_vs_wr_en", slice_pe_reset, c_wr_en);
        if (c_wr_en) begin
          `CHK("cap_start_low", slice_start, 0);
          if (ap_ce) begin
            `CHK("cap_row", row_idx, cap_n / STEPS);
            `CHK("cap_col", col_idx, cap_n % STEPS);
            `CHK("cap_op_count", op_count, cap_n);
            if (chk_lat) `CHK("cap_latency", cyc - issue_cyc, exp_lat);
            cap_n++;
          end
        end
        if (ap_done) begin
          `CHK("done_op_count", op_count, OPS);
          `CHK("done_row", row_idx, STEPS - 1);
          `CHK("done_col", col_idx, STEPS - 1);
        end
        prev_start = &slice_start;
        prev_idle = ap_idle;
      end
    end
  end

  initial begin
    int t0, t1, k;
    set_slices(1, 1, 1, 1, 1'b1);

    // reset state
    tick(2);
    `CHK("rst_idle", ap_idle, 1);
    `CHK("rst_ready", ap_ready, 1);
    `CHK("rst_done", ap_done, 0);
    `CHK("rst_start", slice_start, 0);
    `CHK("rst_pe_reset", slice_pe_reset, 0);
    `CHK("rst_wr_en", c_wr_en, 0);
    `CHK("rst_err", err_timeout, 0);
    `CHK("rst_op_count", op_count, 0);
    ap_rst = 1'b0;
    tick(2);

    // 1: default job, done one cycle after start
    chk_lat = 1'b1;
    set_slices(1, 1, 1, 1, 1'b1);
    start_job(1'b0, t0);
    wait_for_end(1000, t1);
    `CHK("t1_done_cycle", t1 - t0, 194);
    `CHK("t1_done", ap_done, 1);
    `CHK("t1_captures", cap_n, 64);
    `CHK("t1_op_count", op_count, 64);
    `CHK("t1_row", row_idx, 7);
    `CHK("t1_col", col_idx, 7);
`ifdef SEQ_PERF_CNT_EN
    `CHK("t1_busy", busy_cycles, 193);
`else
    `CHK("t1_busy", busy_cycles, 0);
`endif
    tick(2);
    `CHK("t1_done_held", ap_done, 1);
    continue_job();
    `CHK("t1_back_idle", ap_idle, 1);
    `CHK("t1_done_clear", ap_done, 0);

    // 2: staggered done pulses
    set_slices(2, 5, 9, 3, 1'b1);
    `CHK("t2_exp_latency", exp_lat, 10);
    start_job(1'b0, t0);
    wait_for_end(2000, t1);
    `CHK("t2_done_cycle", t1 - t0, 706);
    `CHK("t2_captures", cap_n, 64);
`ifdef SEQ_PERF_CNT_EN
    `CHK("t2_busy", busy_cycles, 705);
`endif
    continue_job();

    // 3: slice 3 never finishes
    chk_lat = 1'b0;
    set_slices(1, 1, 1, -1, 1'b1);
    start_job(1'b0, t0);
    wait_for_end(2000, t1);
    `CHK("t3_err_cycle", t1 - t0, 1027);
    `CHK("t3_err", err_timeout, 1);
    `CHK("t3_start_low", slice_start, 0);
    `CHK("t3_no_done", ap_done, 0);
    `CHK("t3_no_capture", cap_n, 0);
    `CHK("t3_op_count", op_count, 0);
`ifdef SEQ_PERF_CNT_EN
    `CHK("t3_busy", busy_cycles, 1026);
`endif
    tick(3);
    `CHK("t3_err_held", err_timeout, 1);
`ifdef SEQ_PERF_CNT_EN
    `CHK("t3_busy_held", busy_cycles, 1026);
`endif
    continue_job();
    `CHK("t3_idle", ap_idle, 1);
    `CHK("t3_err_clear", err_timeout, 0);

    // 4: clock enable low for 20 cycles at the ISSUE of op 16
    set_slices(1, 1, 1, 1, 1'b0);
    start_job(1'b0, t0);
    tick(49);
    `CHK("t4_pre_row", row_idx, 2);
    `CHK("t4_pre_col", col_idx, 0);
    `CHK("t4_pre_op", op_count, 16);
    `CHK("t4_pre_start", slice_start, {NS{1'b1}});
    ap_ce = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      `CHK("t4_frz_row", row_idx, 2);
      `CHK("t4_frz_col", col_idx, 0);
      `CHK("t4_frz_op", op_count, 16);
      `CHK("t4_frz_start", slice_start, {NS{1'b1}});
`ifdef SEQ_PERF_CNT_EN
      `CHK("t4_frz_busy", busy_cycles, 49);
`endif
    end
    ap_ce = 1'b1;
    wait_for_end(1000, t1);
    `CHK("t4_done_cycle", t1 - t0, 214);
    `CHK("t4_op_count", op_count, 64);
`ifdef SEQ_PERF_CNT_EN
    `CHK("t4_busy", busy_cycles, 193);
`endif
    continue_job();

    // 5: asynchronous reset during WAIT_DONE of op 17
    chk_lat = 1'b1;
    set_slices(5, 5, 5, 5, 1'b0);
    start_job(1'b0, t0);
    k = 0;
    while (!(op_count == 17 && &slice_start) && k < 2000) begin
      tick(1);
      k++;
    end
    tick(1);
    `CHK("t5_row", row_idx, 2);
    `CHK("t5_col", col_idx, 1);
    `CHK("t5_op", op_count, 17);
    #3 ap_rst = 1'b1;
    #1;
    `CHK("t5_rst_idle", ap_idle, 1);
    `CHK("t5_rst_ready", ap_ready, 1);
    `CHK("t5_rst_done", ap_done, 0);
    `CHK("t5_rst_start", slice_start, 0);
    `CHK("t5_rst_pe_reset", slice_pe_reset, 0);
    `CHK("t5_rst_wr_en", c_wr_en, 0);
    `CHK("t5_rst_row", row_idx, 0);
    `CHK("t5_rst_col", col_idx, 0);
    `CHK("t5_rst_op", op_count, 0);
    tick(2);
    ap_rst = 1'b0;
    tick(2);
    `CHK("t5_post_wr_en", c_wr_en, 0);
    `CHK("t5_post_idle", ap_idle, 1);
    set_slices(1, 1, 1, 1, 1'b1);
    start_job(1'b0, t0);
    wait_for_end(1000, t1);
    `CHK("t5_done_cycle", t1 - t0, 194);
    `CHK("t5_captures", cap_n, 64);
    continue_job();

    // 6: ap_start held high, load_done withheld on the second job
    start_job(1'b1, t0);
    wait_for_end(1000, t1);
    `CHK("t6_done_cycle", t1 - t0, 194);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      `CHK("t6_done_held", ap_done, 1);
      `CHK("t6_not_idle", ap_idle, 0);
    end
    load_done = 1'b0;
    continue_job();
    `CHK("t6_idle", ap_idle, 1);
    tick(1);
    `CHK("t6_restart", ap_idle, 0);
    `CHK("t6_restart_done", ap_done, 0);
    `CHK("t6_row_clr", row_idx, 0);
    `CHK("t6_col_clr", col_idx, 0);
    `CHK("t6_op_clr", op_count, 0);
    tick(30);
    `CHK("t6_wait_idle", ap_idle, 0);
    `CHK("t6_wait_start", slice_start, 0);
    `CHK("t6_wait_op", op_count, 0);
    `CHK("t6_wait_caps", cap_n, 0);
    ap_start = 1'b0;
    load_done = 1'b1;
    t0 = cyc;
    wait_for_end(1000, t1);
    `CHK("t6_done2_cycle", t1 - t0, 193);
    `CHK("t6_captures", cap_n, 64);
`ifdef SEQ_PERF_CNT_EN
    `CHK("t6_busy", busy_cycles, 223);
`endif
    continue_job();
    `CHK("t6_end_idle", ap_idle, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
